// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package switch_debouncer_pkg;

  localparam int unsigned DEFAULT_N               = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned CLK_FREQ_HZ             = 100_000_000;
  localparam int unsigned DEBOUNCE_MS             = 10;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

  // Counter width able to hold 0 .. cycles-1 (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_lane.sv
// One switch lane: synchroniser chain followed by a stability counter.
// SYNC_STAGES and DEBOUNCE_CYCLES must both be 2 or more.
module debounce_lane
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept_c
);

  localparam int unsigned        CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_d;
  logic                   rise_d;
  logic                   fall_d;
  logic                   accept;

  // Plain shift chain, nothing between stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Accept a new level only after CNT_MAX+1 consecutive disagreeing cycles.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = o_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;
    if (s == o_level) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign o_accept_c = accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      o_level <= level_d;
      o_rise  <= rise_d;
      o_fall  <= fall_d;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// N independent debounced switch lanes with a shared any-change strobe.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned N               = DEFAULT_N,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_switch,
  output logic [N-1:0] o_switch,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall,
  output logic         o_any_change
);

  logic [N-1:0] accept_c;

  for (genvar k = 0; k < N; k++) begin : g_lane
    debounce_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_raw     (i_switch[k]),
      .o_level   (o_switch[k]),
      .o_rise    (o_rise[k]),
      .o_fall    (o_fall[k]),
      .o_accept_c(accept_c[k])
    );
  end

  // Registered from the same accept terms as the strobes so it lines up with them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_any_change <= 1'b0;
    end else begin
      o_any_change <= |accept_c;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a sliding-window reference model.
`timescale 1ns/1ps
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned D   = SIM_DEBOUNCE_CYCLES;
  localparam int unsigned H   = S + D - 1;
  localparam int          LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [N-1:0] o_switch, o_rise, o_fall;
  logic         o_any_change;
  logic         cmp_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(.N(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_switch    (sw),
    .o_switch    (o_switch),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_any_change(o_any_change)
  );

  always #500 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a lane takes value v at edge t when the raw pin was v at the D
  // samples taken S..S+D-1 edges earlier and v differs from the current level.
  logic [H-1:0][N-1:0] hist;
  logic [N-1:0]        m_sw, m_rise, m_fall;
  logic                m_any;

  function automatic logic [N-1:0] accept_vec(input logic [H-1:0][N-1:0] h,
                                              input logic [N-1:0] lvl);
    logic [N-1:0] a;
    for (int k = 0; k < N; k++) begin
      logic stable;
      stable = 1'b1;
      for (int j = S - 1; j < H; j++)
        if (h[j][k] != h[S-1][k]) stable = 1'b0;
      a[k] = stable && (h[S-1][k] != lvl[k]);
    end
    return a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      m_sw   <= '0;
      m_rise <= '0;
      m_fall <= '0;
      m_any  <= 1'b0;
    end else begin
      m_sw   <= m_sw ^ accept_vec(hist, m_sw);
      m_rise <= accept_vec(hist, m_sw) & hist[S-1];
      m_fall <= accept_vec(hist, m_sw) & ~hist[S-1];
      m_any  <= |accept_vec(hist, m_sw);
      hist   <= {hist[H-2:0], sw};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_switch", 32'(o_switch), 32'(m_sw));
      chk("model_rise",   32'(o_rise),   32'(m_rise));
      chk("model_fall",   32'(o_fall),   32'(m_fall));
      chk("model_any",    32'(o_any_change), 32'(m_any));
    end
  end

  task automatic apply(input logic [N-1:0] v);
    @(negedge clk);
    sw = v;
  endtask

  // Literal expectations: output changes at edge LAT after the first sampling edge.
  task automatic watch(input string name, input logic [N-1:0] new_sw, input logic [N-1:0] old_sw,
                       input logic [N-1:0] exp_rise, input logic [N-1:0] exp_fall);
    for (int e = 1; e <= LAT + 2; e++) begin
      @(posedge clk);
      #1;
      if (e == LAT) begin
        chk({name, "_sw"},   32'(o_switch), 32'(new_sw));
        chk({name, "_rise"}, 32'(o_rise),   32'(exp_rise));
        chk({name, "_fall"}, 32'(o_fall),   32'(exp_fall));
        chk({name, "_any"},  32'(o_any_change), 32'((exp_rise | exp_fall) != '0));
      end else begin
        chk({name, "_sw_hold"}, 32'(o_switch), 32'((e < LAT) ? old_sw : new_sw));
        chk({name, "_nostrobe"}, 32'({o_rise, o_fall, o_any_change}), 32'(0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 4'b1111;
    repeat (3) @(negedge clk);
    #100;
    chk("reset_sw",   32'(o_switch), 32'(0));
    chk("reset_rise", 32'(o_rise),   32'(0));
    chk("reset_fall", 32'(o_fall),   32'(0));
    chk("reset_any",  32'(o_any_change), 32'(0));
    cmp_en = 1'b1;
    @(negedge clk);
    #100;
    rst_n = 1'b1;
    watch("power_on", 4'b1111, 4'b0000, 4'b1111, 4'b0000);

    apply(4'b0000);
    watch("to_zero", 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    apply(4'b0100);
    watch("clean_edge", 4'b0100, 4'b0000, 4'b0100, 4'b0000);

    // Three-cycle glitch on lane 0.
    apply(4'b0101);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) sw = 4'b0100;
      chk("glitch_sw", 32'(o_switch), 32'(4'b0100));
      chk("glitch_any", 32'(o_any_change), 32'(0));
    end

    // Bounce on lane 3, then hold high.
    for (int i = 0; i < 4; i++) begin
      apply((i % 2 == 0) ? 4'b1100 : 4'b0100);
      @(posedge clk);
      #1;
      chk("bounce_rise", 32'(o_rise), 32'(0));
    end
    apply(4'b1100);
    watch("bounce", 4'b1100, 4'b0100, 4'b1000, 4'b0000);

    apply(4'b1010);
    watch("set_1010", 4'b1010, 4'b1100, 4'b0010, 4'b0100);
    apply(4'b0101);
    watch("multi", 4'b0101, 4'b1010, 4'b0101, 4'b1010);

    // Reset two edges into a 0->1 count on lane 3.
    apply(4'b1101);
    repeat (2) @(posedge clk);
    #100;
    rst_n = 1'b0;
    #1;
    chk("midrst_sw",   32'(o_switch), 32'(0));
    chk("midrst_strb", 32'({o_rise, o_fall, o_any_change}), 32'(0));
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk("midrst_hold", 32'({o_switch, o_rise, o_fall, o_any_change}), 32'(0));
    end
    @(negedge clk);
    #100;
    rst_n = 1'b1;
    watch("midrst_rel", 4'b1101, 4'b0000, 4'b1101, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-side conditioner for board slide switches. It feeds clean levels to the switch-to-LED path and to NoC control logic.
- Each raw, asynchronous switch bit passes through a synchroniser and then a per-bit stability counter.
- Outputs per bit: a debounced level, plus single-cycle rise and fall strobes.
- Sits between the FPGA pins and any logic that consumes i_switch-style inputs.

Parameters:
- N, 4, number of switch lanes.
- SYNC_STAGES, 2, synchroniser flop depth per lane; must be 2 or more.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); must be 2 or more.

Ports:
- i_clk  input  1  system clock; all state is on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_switch  input  N  raw switch pins, asynchronous to i_clk.
- o_switch  output  N  debounced switch level.
- o_rise  output  N  one-cycle strobe when o_switch[k] goes 0->1.
- o_fall  output  N  one-cycle strobe when o_switch[k] goes 1->0.
- o_any_change  output  1  OR of all bits of o_rise and o_fall, registered with them in the same cycle.

Behaviour:
- Reset (i_rst_n=0, asynchronous assert):
  - synchroniser flops, counters, o_switch, o_rise, o_fall and o_any_change all clear to 0 immediately.
  - Reset is released synchronously to i_clk by the board-level reset bridge; this block does not re-synchronise it.
- Synchroniser: lane k shifts i_switch[k] through SYNC_STAGES flops. The last stage is s[k]. No logic is allowed between synchroniser stages.
- Counter: cnt[k] has width $clog2(DEBOUNCE_CYCLES). Per lane, each cycle:
  - If s[k] == o_switch[k]: cnt[k] <= 0.
  - Else if cnt[k] == DEBOUNCE_CYCLES-1: o_switch[k] <= s[k]; cnt[k] <= 0; the matching strobe is asserted next cycle.
  - Else: cnt[k] <= cnt[k]+1.
- Strobes:
  - o_rise[k] and o_fall[k] are registered and high for exactly one cycle.
  - They are asserted in the same cycle that o_switch[k] shows its new value.
  - They are mutually exclusive per lane.
- Latency: after i_switch[k] changes and then stays stable, o_switch[k] updates exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new value.
- Glitch rejection: any excursion of s[k] lasting fewer than DEBOUNCE_CYCLES cycles produces no output change and no strobe. The counter restarts from 0 on every return to the accepted level.
- Lanes are fully independent. Simultaneous changes on several lanes give simultaneous strobes, and o_any_change is asserted for one cycle only.
- Back-to-back toggles: a new opposite transition needs a full DEBOUNCE_CYCLES of stability after the previous acceptance. There is no minimum gap beyond that.
- Counter wrap: the counter can never exceed DEBOUNCE_CYCLES-1.
- Reset mid-count: all in-progress counts are discarded and no strobe is emitted.
  - After reset release, a switch held at 1 is accepted as a normal 0->1 transition, so o_rise pulses once after the full latency.
  - This is intentional: downstream logic sees the power-on state as an event.

Decomposition:
- Shared include (switches_defs.vh):
  - default N;
  - CLK_FREQ_HZ = 100000000;
  - DEBOUNCE_MS = 10, with DEBOUNCE_CYCLES derived from CLK_FREQ_HZ and DEBOUNCE_MS;
  - SIM_DEBOUNCE_CYCLES = 4 for benches.
- One sub-module, debounce_lane:
  - ports i_clk, i_rst_n, i_raw, o_level, o_rise, o_fall;
  - parameters SYNC_STAGES and DEBOUNCE_CYCLES.
- The top level instantiates N lanes in a generate loop and ORs the strobes into o_any_change.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 1 us clock):
- Reset check: hold i_rst_n=0 with i_switch=4'b1111.
  - All outputs are 0 during reset.
  - After release: o_switch=4'b1111 exactly 6 edges later; o_rise=4'b1111 for one cycle; o_any_change=1 for one cycle.
- Clean edge: from a settled 4'b0000, set i_switch=4'b0100.
  - o_switch=4'b0100 after 6 edges.
  - o_rise=4'b0100 for one cycle; o_fall=0.
- Glitch: pulse i_switch[0] high for 3 cycles, then low.
  - o_switch[0] stays 0; no strobe on any lane.
- Bounce: toggle i_switch[3] 1/0/1/0/1 at 1-cycle spacing, then hold 1.
  - Exactly one o_rise[3] pulse, 6 edges after the final 0->1.
- Multi-lane: change from 4'b1010 to 4'b0101 in one cycle.
  - o_rise=4'b0101 and o_fall=4'b1010 in the same cycle.
  - o_any_change high for exactly one cycle.
- Reset mid-count: assert i_rst_n=0 two cycles into a 0->1 count.
  - Outputs clear immediately; no strobe is emitted during reset.
  - After release, the count restarts and o_rise pulses once, 6 edges later.
